// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the UART boot loader
package boot_pkg;
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERROR} state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchroniser, mid-bit sampling and start-bit recheck
module uart_rx #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW = $clog2(DIV);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t rx_state, rx_next;
  logic s1, s2, s3;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic half, full;
  assign half = cnt == CW'(DIV / 2 - 1);
  assign full = cnt == CW'(DIV - 1);
  // receiver state register
  always_ff @(posedge clk or posedge reset)
    if (reset) rx_state <= RX_IDLE;
    else rx_state <= rx_next;
  // next state: a falling edge starts a frame, a high line at mid-start aborts it
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (s3 && !s2) rx_next = RX_START;
      RX_START: if (half) rx_next = s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (full) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end
  // synchroniser, bit timer, LSB-first shift and the one-cycle byte strobe
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      cnt <= '0;
      bit_idx <= '0;
      byte_data <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
      cnt <= (rx_state == RX_IDLE || rx_next != rx_state || full) ? '0 : cnt + 1'b1;
      byte_valid <= rx_state == RX_STOP && full;
      frame_err <= rx_state == RX_STOP && full && !s2;
      if (rx_state == RX_DATA && full) begin
        byte_data <= {s2, byte_data[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a checksummed program image from UART into memory, then releases the core
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int          CLK_HZ = 12000000,
  parameter int          BAUD = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        mem_wren,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        core_reset,
  output logic        busy,
  output logic        error
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  state_t state, next;
  logic [7:0] byte_data, cnt_lo, checksum;
  logic byte_valid, frame_err, good, is_sync, last_byte, last_word, count_bad;
  logic [15:0] count, new_count;
  logic [IW-1:0] idx;
  logic [1:0] lane;
  logic core_reset_d, busy_d, error_d;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .frame_err(frame_err)
  );

  assign good = byte_valid && !frame_err;
  assign is_sync = good && byte_data == SYNC_BYTE;
  assign last_byte = lane == 2'(WORD_BYTES - 1);
  assign last_word = 32'(idx) == 32'(count) - 32'd1;
  assign new_count = {byte_data, cnt_lo};
  assign count_bad = new_count == '0 || int'(new_count) > MAX_WORDS;

  // loader state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // next state: framing errors abort a load, a sync byte (re)starts one
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (is_sync) next = CNT_LO;
      CNT_LO:  if (byte_valid) next = frame_err ? ERROR : CNT_HI;
      CNT_HI:  if (byte_valid) next = (frame_err || count_bad) ? ERROR : DATA;
      DATA:    if (byte_valid) next = frame_err ? ERROR : (last_byte && last_word) ? CHECK : DATA;
      CHECK:   if (byte_valid) next = (frame_err || byte_data != checksum) ? ERROR : DONE;
      DONE:    next = DONE;
      ERROR:   if (is_sync) next = CNT_LO;
      default: next = IDLE;
    endcase
  end
  // status decoded from the upcoming state so the registered outputs change on the transition edge
  always_comb begin
    core_reset_d = next != DONE;
    busy_d = next inside {CNT_LO, CNT_HI, DATA, CHECK};
    error_d = next == ERROR;
  end
  // registered status outputs keep core_reset glitch-free
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      core_reset <= 1'b1;
      busy <= 1'b0;
      error <= 1'b0;
    end else begin
      core_reset <= core_reset_d;
      busy <= busy_d;
      error <= error_d;
    end
  // count capture, little-endian word assembly, checksum and the write strobe
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_lo <= '0;
      count <= '0;
      idx <= '0;
      lane <= '0;
      checksum <= '0;
      mem_wren <= 1'b0;
      mem_address <= BASE_ADDR;
      mem_data <= '0;
    end else begin
      mem_wren <= 1'b0;
      if (good && state == CNT_LO) cnt_lo <= byte_data;
      if (good && state == CNT_HI) begin
        count <= new_count;
        idx <= '0;
        lane <= '0;
        checksum <= '0;
      end
      if (good && state == DATA) begin
        mem_data[8*lane +: 8] <= byte_data;
        checksum <= checksum + byte_data;
        lane <= lane + 1'b1;
        if (last_byte) begin
          mem_wren <= 1'b1;
          mem_address <= BASE_ADDR + 32'({idx, 2'b00});
          idx <= idx + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed self-checking bench for the UART boot loader
module tb_uart_boot_loader;
  localparam int DIV = 10;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1;
  logic mem_wren, core_reset, busy, error;
  logic [31:0] mem_address, mem_data;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, bv_cyc = -100, cr_lat = -1, lat_bad = 0, wide = 0;
  logic prev_wren = 1'b0, prev_cr = 1'b1;
  logic [31:0] wa[$], wd[$];
  logic [7:0] tx[$];
  logic [7:0] img [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
  logic [7:0] good_cs;

  always #5 clk = ~clk;

  uart_boot_loader #(.CLK_HZ(1000000), .BAUD(100000), .BASE_ADDR(32'h0), .MAX_WORDS(2048)) dut (
    .clk(clk), .reset(reset), .rx(rx), .mem_wren(mem_wren), .mem_address(mem_address),
    .mem_data(mem_data), .core_reset(core_reset), .busy(busy), .error(error)
  );

  // write log, strobe width, and latencies measured from the receiver's byte strobe
  always @(negedge clk) begin
    cyc++;
    if (dut.u_rx.byte_valid) bv_cyc = cyc;
    if (mem_wren) begin
      wa.push_back(mem_address);
      wd.push_back(mem_data);
      if (cyc - bv_cyc != 1) lat_bad++;
      if (prev_wren) wide++;
    end
    if (prev_cr && !core_reset) cr_lat = cyc - bv_cyc;
    prev_wren = mem_wren;
    prev_cr = core_reset;
  end

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return i < q.size() ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic send_bit(input logic v);
    rx = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic send_tx();
    while (tx.size() > 0) send_byte(tx.pop_front(), 1'b1);
  endtask

  task automatic push_frame(input logic [7:0] cs);
    tx.push_back(8'hA5);
    tx.push_back(8'h02);
    tx.push_back(8'h00);
    for (int i = 0; i < 8; i++) tx.push_back(img[i]);
    tx.push_back(cs);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    lat_bad = 0;
    wide = 0;
    cr_lat = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 clear_log();
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL reset_core_reset: got %b expected 1", core_reset); end
    n_checks++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wren: got %b expected 0", mem_wren); end
    n_checks++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
    n_checks++; if (mem_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_data: got %h expected 0", mem_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
  endtask

  task automatic test_good_load();
    do_reset();
    send_byte(8'hA5, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL good_sync_busy: got %b expected 1", busy); end
    push_frame(good_cs);
    void'(tx.pop_front());
    send_tx();
    settle();
    n_checks++; if (wa.size() !== 2) begin n_fail++; $display("FAIL good_nwrites: got %0d expected 2", wa.size()); end
    n_checks++; if (qget(wa, 0) !== 32'h0) begin n_fail++; $display("FAIL good_addr0: got %h expected 00000000", qget(wa, 0)); end
    n_checks++; if (qget(wd, 0) !== 32'h0010_0513) begin n_fail++; $display("FAIL good_data0: got %h expected 00100513", qget(wd, 0)); end
    n_checks++; if (qget(wa, 1) !== 32'h4) begin n_fail++; $display("FAIL good_addr1: got %h expected 00000004", qget(wa, 1)); end
    n_checks++; if (qget(wd, 1) !== 32'h0020_0593) begin n_fail++; $display("FAIL good_data1: got %h expected 00200593", qget(wd, 1)); end
    n_checks++; if (lat_bad !== 0) begin n_fail++; $display("FAIL good_wren_latency: got %0d late writes expected 0", lat_bad); end
    n_checks++; if (wide !== 0) begin n_fail++; $display("FAIL good_wren_width: got %0d extra strobe cycles expected 0", wide); end
    n_checks++; if (cr_lat !== 1) begin n_fail++; $display("FAIL good_core_reset_latency: got %0d expected 1", cr_lat); end
    n_checks++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL good_core_reset: got %b expected 0", core_reset); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL good_error: got %b expected 0", error); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy: got %b expected 0", busy); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    push_frame(8'h00);
    send_tx();
    settle();
    n_checks++; if (wa.size() !== 2) begin n_fail++; $display("FAIL badcs_nwrites: got %0d expected 2", wa.size()); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL badcs_error: got %b expected 1", error); end
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL badcs_core_reset: got %b expected 1", core_reset); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badcs_busy: got %b expected 0", busy); end
    clear_log();
    push_frame(good_cs);
    send_tx();
    settle();
    n_checks++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL retry_core_reset: got %b expected 0", core_reset); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL retry_error: got %b expected 0", error); end
    n_checks++; if (qget(wd, 1) !== 32'h0020_0593) begin n_fail++; $display("FAIL retry_data1: got %h expected 00200593", qget(wd, 1)); end
  endtask

  task automatic test_count_bounds();
    do_reset();
    tx = '{8'hA5, 8'h00, 8'h00};
    send_tx();
    settle();
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL count0_error: got %b expected 1", error); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL count0_busy: got %b expected 0", busy); end
    send_byte(8'hA5, 1'b1);
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL resync_error: got %b expected 0", error); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL resync_busy: got %b expected 1", busy); end
    tx = '{8'h01, 8'h08};
    send_tx();
    settle();
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL countmax_error: got %b expected 1", error); end
    n_checks++; if (wa.size() !== 0) begin n_fail++; $display("FAIL count_nwrites: got %0d expected 0", wa.size()); end
  endtask

  task automatic test_frame_err();
    do_reset();
    tx = '{8'hA5, 8'h02, 8'h00, 8'h13};
    send_tx();
    send_byte(8'h05, 1'b0);
    settle();
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL ferr_error: got %b expected 1", error); end
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL ferr_core_reset: got %b expected 1", core_reset); end
    n_checks++; if (wa.size() !== 0) begin n_fail++; $display("FAIL ferr_nwrites: got %0d expected 0", wa.size()); end
  endtask

  task automatic test_noise();
    do_reset();
    tx = '{8'h00, 8'hFF};
    send_tx();
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * DIV) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noise_busy: got %b expected 0", busy); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL noise_error: got %b expected 0", error); end
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL noise_core_reset: got %b expected 1", core_reset); end
    push_frame(good_cs);
    send_tx();
    settle();
    n_checks++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL noise_load_core_reset: got %b expected 0", core_reset); end
    n_checks++; if (wa.size() !== 2) begin n_fail++; $display("FAIL noise_nwrites: got %0d expected 2", wa.size()); end
    n_checks++; if (qget(wa, 1) !== 32'h4) begin n_fail++; $display("FAIL noise_addr1: got %h expected 00000004", qget(wa, 1)); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05};
    send_tx();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b expected 0", busy); end
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL async_core_reset: got %b expected 1", core_reset); end
    n_checks++; if (mem_data !== 32'h0) begin n_fail++; $display("FAIL async_mem_data: got %h expected 0", mem_data); end
    n_checks++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL async_mem_address: got %h expected 0", mem_address); end
    n_checks++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL async_mem_wren: got %b expected 0", mem_wren); end
    do_reset();
    push_frame(good_cs);
    send_tx();
    settle();
    n_checks++; if (wa.size() !== 2) begin n_fail++; $display("FAIL reload_nwrites: got %0d expected 2", wa.size()); end
    n_checks++; if (qget(wa, 0) !== 32'h0) begin n_fail++; $display("FAIL reload_addr0: got %h expected 00000000", qget(wa, 0)); end
    n_checks++; if (qget(wd, 0) !== 32'h0010_0513) begin n_fail++; $display("FAIL reload_data0: got %h expected 00100513", qget(wd, 0)); end
    n_checks++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL reload_core_reset: got %b expected 0", core_reset); end
  endtask

  initial begin
    good_cs = 8'h00;
    for (int i = 0; i < 8; i++) good_cs = good_cs + img[i];
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_count_bounds();
    test_frame_err();
    test_noise();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
